op_sequencer: RTL and testbench
===============================

OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries, power of two, minimum 2.
REQ-002 Parameter MUL_CYCLES, default 64: cycles opcode 1 is held on operation (W cells x X lines).
REQ-003 Parameter DRAIN, default 16: idle cycles after a multiply so results flush from the multiplier.
REQ-004 Parameter LOAD_WORDS, default 64: data words per opcode-2 command.
REQ-005 clk  input  1  sole clock; all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high; dominates enable.
REQ-007 enable  input  1  global enable; when low, no state, counter or FIFO changes.
REQ-008 cmd_valid / cmd_ready / cmd  input / output / input  1 / 1 / 32  host command push; cmd uses the operation word format.
REQ-009 data_valid / data_ready / data  input / output / input  1 / 1 / 32  serial page-load data stream.
REQ-010 operation  output  32  operation word driven to the matrix controller.
REQ-011 in_data  output  32  data word driven to the matrix controller.
REQ-012 busy  output  1  high when state != IDLE or FIFO non-empty.
REQ-013 done  output  1  one-cycle pulse per completed command.
REQ-014 err  output  1  sticky illegal-opcode flag.

Function
REQ-015 FIFO push on cmd_valid && cmd_ready; cmd_ready = enable && !full; no push-to-pop bypass, so a command pushed at cycle T is poppable at T+1 at the earliest.
REQ-016 FIFO pop only in state IDLE with enable high and FIFO non-empty; the head is latched into cur.
REQ-017 States: IDLE, MUL, DRAIN, LOAD; encoding is free.
REQ-018 On pop, dispatch on cur[3:0]: 1 -> MUL with counter 0; 2 -> LOAD with counter 0; 0 -> stay IDLE and pulse done next cycle; any other value -> stay IDLE, set err, no done.
REQ-019 MUL: operation = cur for exactly MUL_CYCLES consecutive enabled cycles, then DRAIN.
REQ-020 DRAIN: operation = 0 for exactly DRAIN enabled cycles, then IDLE; done high on the first IDLE cycle.
REQ-021 LOAD: data_ready = enable; on each data_valid && data_ready cycle, operation = cur and in_data = data; on all other cycles operation = 0.
REQ-022 LOAD: after the LOAD_WORDS-th transfer, go to IDLE and pulse done on the next cycle.
REQ-023 Outside MUL and LOAD transfer cycles, operation = 0 and in_data = 0; data_ready = 0 outside LOAD.
REQ-024 A pop may occur in the same cycle done is high, so back-to-back commands lose no further cycles.
REQ-025 enable low mid-command freezes state, counters and outputs; the count resumes where it stopped, and frozen cycles do not count.
REQ-026 Counters are wide enough for max(MUL_CYCLES, DRAIN, LOAD_WORDS) with no wrap; terminal compares are exact equality.
REQ-027 Pushing while full is blocked by cmd_ready = 0; commands are never dropped or overwritten.
REQ-028 err is cleared only by reset.

Reset
REQ-029 With reset high at a posedge: FIFO empty, state IDLE, counters 0, cur 0, err 0.
REQ-030 During and after reset, all outputs are 0 (operation, in_data, busy, done, err, data_ready) and cmd_ready = 0 until the first cycle with reset low and enable high.
REQ-031 Reset mid-MUL or mid-LOAD aborts the command with no done pulse and discards queued commands.

Verification
REQ-032 Push 0x00003201 at cycle 0 -> operation = 0x00003201 in cycles 2..65, 0 in cycles 66..81, done in cycle 82 only, busy low from cycle 82.
REQ-033 Push 0x00000082, then stream 64 words with data_valid toggling every cycle -> operation nonzero only on the 64 transfer cycles, in_data matches each word, then one done pulse.
REQ-034 Push 5 commands back-to-back with DEPTH 4 while a MUL is running -> cmd_ready low after the 4th is queued; all commands execute in order; 5 done pulses total.
REQ-035 Push opcode 0x7 then opcode 0 -> err rises and stays high; exactly one done (for opcode 0); operation stays 0.
REQ-036 Drop enable for 10 cycles in the middle of MUL -> total opcode-1 cycles still 64; done is delayed by exactly 10 cycles.
REQ-037 Assert reset at cycle 30 of MUL with 2 commands queued -> all outputs 0 the next cycle, no done, FIFO empty, busy 0.

Source files
------------

// File: rtl/op_sequencer.sv
// Command sequencer: queues 32-bit operation words from a host and plays them
// out to the matrix controller as multiply runs (with drain) or page loads.
module op_sequencer #(
    parameter int DEPTH      = 4,
    parameter int MUL_CYCLES = 64,
    parameter int DRAIN      = 16,
    parameter int LOAD_WORDS = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [31:0] i_cmd,
    input  logic        i_data_valid,
    output logic        o_data_ready,
    input  logic [31:0] i_data,
    output logic [31:0] o_operation,
    output logic [31:0] o_in_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAX_A   = (MUL_CYCLES > DRAIN) ? MUL_CYCLES : DRAIN;
    localparam int MAX_CNT = (MAX_A > LOAD_WORDS) ? MAX_A : LOAD_WORDS;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] MUL_LAST   = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W:0]   PTR_ONE    = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DRAIN,
        S_LOAD
    } state_t;

    state_t             r_state;
    logic [31:0]        r_fifo [DEPTH];
    logic [PTR_W:0]     r_wrPtr;
    logic [PTR_W:0]     r_rdPtr;
    logic [31:0]        r_cur;
    logic [CNT_W-1:0]   r_count;
    logic               r_done;
    logic               r_err;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_xfer;
    logic [31:0]        w_head;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                     (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign w_head  = r_fifo[r_rdPtr[PTR_W-1:0]];
    assign w_push  = i_cmd_valid && o_cmd_ready;
    assign w_pop   = i_enable && (r_state == S_IDLE) && !w_empty;
    assign w_xfer  = i_enable && (r_state == S_LOAD) && i_data_valid;

    // Every output is forced low while reset is asserted, before the edge lands.
    assign o_cmd_ready  = !i_reset && i_enable && !w_full;
    assign o_data_ready = !i_reset && i_enable && (r_state == S_LOAD);
    assign o_operation  = (!i_reset && ((r_state == S_MUL) || w_xfer)) ? r_cur : 32'd0;
    assign o_in_data    = (!i_reset && w_xfer) ? i_data : 32'd0;
    assign o_busy       = !i_reset && ((r_state != S_IDLE) || !w_empty);
    assign o_done       = !i_reset && r_done;
    assign o_err        = !i_reset && r_err;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wrPtr[PTR_W-1:0]] <= i_cmd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

    // Nothing advances on disabled cycles, so frozen cycles never count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_cur   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_enable) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur   <= w_head;
                        r_count <= '0;
                        case (w_head[3:0])
                            4'd0:    r_done  <= 1'b1;
                            4'd1:    r_state <= S_MUL;
                            4'd2:    r_state <= S_LOAD;
                            default: r_err   <= 1'b1;
                        endcase
                    end
                end
                S_MUL: begin
                    if (r_count == MUL_LAST) begin
                        r_state <= S_DRAIN;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (r_count == DRAIN_LAST) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                S_LOAD: begin
                    if (i_data_valid) begin
                        if (r_count == LOAD_LAST) begin
                            r_state <= S_IDLE;
                            r_count <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: each task drives one scenario cycle by cycle
// and compares outputs against hand-computed cycle numbers.
module tb_op_sequencer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        cmdValid;
    logic        cmdReady;
    logic [31:0] cmd;
    logic        dataValid;
    logic        dataReady;
    logic [31:0] data;
    logic [31:0] operation;
    logic [31:0] inData;
    logic        busy;
    logic        done;
    logic        err;

    int passCount = 0;
    int checkCount = 0;

    op_sequencer #(
        .DEPTH(4), .MUL_CYCLES(64), .DRAIN(16), .LOAD_WORDS(64)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable),
        .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady), .i_cmd(cmd),
        .i_data_valid(dataValid), .o_data_ready(dataReady), .i_data(data),
        .o_operation(operation), .o_in_data(inData),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Inputs change 1ns after a rising edge; outputs are sampled 4ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        reset = 1'b1; enable = 1'b1; cmdValid = 1'b0; dataValid = 1'b0;
        cmd = '0; data = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; cmdValid = 1'b1; cmd = 32'h1;
        dataValid = 1'b1; data = 32'hFFFF_FFFF;
        step(); step();
        #4;
        checkCount++; if (cmdReady !== 1'b0) $display("[TB] FAIL rst_cmd_ready got %b expected 0", cmdReady); else passCount++;
        checkCount++; if (operation !== 32'd0) $display("[TB] FAIL rst_operation got %h expected 0", operation); else passCount++;
        checkCount++; if (inData !== 32'd0) $display("[TB] FAIL rst_in_data got %h expected 0", inData); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy got %b expected 0", busy); else passCount++;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL rst_done got %b expected 0", done); else passCount++;
        checkCount++; if (err !== 1'b0) $display("[TB] FAIL rst_err got %b expected 0", err); else passCount++;
        checkCount++; if (dataReady !== 1'b0) $display("[TB] FAIL rst_data_ready got %b expected 0", dataReady); else passCount++;
        step();
        reset = 1'b0; enable = 1'b0; cmdValid = 1'b0; dataValid = 1'b0; data = '0;
        #4;
        checkCount++; if (cmdReady !== 1'b0) $display("[TB] FAIL disabled_cmd_ready got %b expected 0", cmdReady); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL post_rst_busy got %b expected 0", busy); else passCount++;
        step();
        enable = 1'b1;
        #4;
        checkCount++; if (cmdReady !== 1'b1) $display("[TB] FAIL enabled_cmd_ready got %b expected 1", cmdReady); else passCount++;
        step();
    endtask

    task automatic test_mul();
        logic [31:0] c0 = 32'h0000_3201;
        logic [31:0] expOp;
        for (int c = 0; c <= 90; c++) begin
            cmdValid = (c == 0);
            cmd = c0;
            #4;
            if (c == 0) begin
                checkCount++; if (cmdReady !== 1'b1) $display("[TB] FAIL mul_cmd_ready got %b expected 1", cmdReady); else passCount++;
            end
            expOp = (c >= 2 && c <= 65) ? c0 : 32'd0;
            checkCount++; if (operation !== expOp) $display("[TB] FAIL mul_op cycle %0d got %h expected %h", c, operation, expOp); else passCount++;
            checkCount++; if (done !== (c == 82)) $display("[TB] FAIL mul_done cycle %0d got %b expected %b", c, done, (c == 82)); else passCount++;
            checkCount++; if (busy !== (c >= 1 && c < 82)) $display("[TB] FAIL mul_busy cycle %0d got %b expected %b", c, busy, (c >= 1 && c < 82)); else passCount++;
            step();
        end
        cmdValid = 1'b0;
    endtask

    task automatic test_load();
        logic [31:0] c0 = 32'h0000_0082;
        logic        xfer;
        logic [31:0] word;
        for (int c = 0; c <= 132; c++) begin
            cmdValid = (c == 0);
            cmd = c0;
            dataValid = (c % 2 == 0);
            word = 32'hA500_0000 | 32'(c);
            data = word;
            #4;
            xfer = (c >= 2) && (c <= 128) && (c % 2 == 0);
            checkCount++; if (operation !== (xfer ? c0 : 32'd0)) $display("[TB] FAIL load_op cycle %0d got %h expected %h", c, operation, (xfer ? c0 : 32'd0)); else passCount++;
            checkCount++; if (inData !== (xfer ? word : 32'd0)) $display("[TB] FAIL load_in_data cycle %0d got %h expected %h", c, inData, (xfer ? word : 32'd0)); else passCount++;
            checkCount++; if (dataReady !== (c >= 2 && c <= 128)) $display("[TB] FAIL load_data_ready cycle %0d got %b expected %b", c, dataReady, (c >= 2 && c <= 128)); else passCount++;
            checkCount++; if (done !== (c == 129)) $display("[TB] FAIL load_done cycle %0d got %b expected %b", c, done, (c == 129)); else passCount++;
            step();
        end
        cmdValid = 1'b0; dataValid = 1'b0; data = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] cmds [6] = '{32'h0000_0A01, 32'h0000_0B01, 32'h0000_0C00,
                                  32'h0000_0D01, 32'h0000_0E00, 32'h0000_0F01};
        logic [31:0] expOp;
        logic        expDone;
        int          doneCount = 0;
        for (int c = 0; c <= 250; c++) begin
            cmdValid = (c <= 5);
            cmd = (c <= 5) ? cmds[c] : 32'd0;
            #4;
            if (c <= 5) begin
                checkCount++; if (cmdReady !== (c <= 4)) $display("[TB] FAIL b2b_cmd_ready cycle %0d got %b expected %b", c, cmdReady, (c <= 4)); else passCount++;
            end
            if (c >= 2 && c <= 65) expOp = cmds[0];
            else if (c >= 83 && c <= 146) expOp = cmds[1];
            else if (c >= 165 && c <= 228) expOp = cmds[3];
            else expOp = 32'd0;
            expDone = (c == 82) || (c == 163) || (c == 164) || (c == 245) || (c == 246);
            if (done === 1'b1) doneCount++;
            checkCount++; if (operation !== expOp) $display("[TB] FAIL b2b_op cycle %0d got %h expected %h", c, operation, expOp); else passCount++;
            checkCount++; if (done !== expDone) $display("[TB] FAIL b2b_done cycle %0d got %b expected %b", c, done, expDone); else passCount++;
            checkCount++; if (busy !== (c >= 1 && c <= 245)) $display("[TB] FAIL b2b_busy cycle %0d got %b expected %b", c, busy, (c >= 1 && c <= 245)); else passCount++;
            step();
        end
        cmdValid = 1'b0;
        checkCount++; if (doneCount != 5) $display("[TB] FAIL b2b_done_count got %0d expected 5", doneCount); else passCount++;
    endtask

    task automatic test_illegal();
        for (int c = 0; c <= 8; c++) begin
            cmdValid = (c <= 1);
            cmd = (c == 0) ? 32'h0000_0007 : 32'h0000_0000;
            #4;
            if (c <= 1) begin
                checkCount++; if (cmdReady !== 1'b1) $display("[TB] FAIL ill_cmd_ready cycle %0d got %b expected 1", c, cmdReady); else passCount++;
            end
            checkCount++; if (err !== (c >= 2)) $display("[TB] FAIL ill_err cycle %0d got %b expected %b", c, err, (c >= 2)); else passCount++;
            checkCount++; if (done !== (c == 3)) $display("[TB] FAIL ill_done cycle %0d got %b expected %b", c, done, (c == 3)); else passCount++;
            checkCount++; if (operation !== 32'd0) $display("[TB] FAIL ill_op cycle %0d got %h expected 0", c, operation); else passCount++;
            step();
        end
        cmdValid = 1'b0;
        resetDut();
        #4;
        checkCount++; if (err !== 1'b0) $display("[TB] FAIL ill_err_cleared got %b expected 0", err); else passCount++;
        step();
    endtask

    task automatic test_enable_freeze();
        logic [31:0] c0 = 32'h0000_3201;
        logic [31:0] expOp;
        int          opCycles = 0;
        for (int c = 0; c <= 100; c++) begin
            cmdValid = (c == 0);
            cmd = c0;
            enable = !(c >= 20 && c <= 29);
            #4;
            if (enable && operation === c0) opCycles++;
            expOp = (c >= 2 && c <= 75) ? c0 : 32'd0;
            checkCount++; if (operation !== expOp) $display("[TB] FAIL frz_op cycle %0d got %h expected %h", c, operation, expOp); else passCount++;
            checkCount++; if (done !== (c == 92)) $display("[TB] FAIL frz_done cycle %0d got %b expected %b", c, done, (c == 92)); else passCount++;
            if (c == 25) begin
                checkCount++; if (cmdReady !== 1'b0) $display("[TB] FAIL frz_cmd_ready got %b expected 0", cmdReady); else passCount++;
            end
            step();
        end
        cmdValid = 1'b0; enable = 1'b1;
        checkCount++; if (opCycles != 64) $display("[TB] FAIL frz_op_cycles got %0d expected 64", opCycles); else passCount++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] cmds [3] = '{32'h0000_3201, 32'h0000_0101, 32'h0000_0000};
        for (int c = 0; c <= 60; c++) begin
            cmdValid = (c <= 2);
            cmd = (c <= 2) ? cmds[c] : 32'd0;
            reset = (c == 31);
            #4;
            if (c == 30) begin
                checkCount++; if (operation !== cmds[0]) $display("[TB] FAIL abort_pre_op got %h expected %h", operation, cmds[0]); else passCount++;
                checkCount++; if (busy !== 1'b1) $display("[TB] FAIL abort_pre_busy got %b expected 1", busy); else passCount++;
            end
            if (c >= 31) begin
                checkCount++; if (operation !== 32'd0) $display("[TB] FAIL abort_op cycle %0d got %h expected 0", c, operation); else passCount++;
                checkCount++; if (done !== 1'b0) $display("[TB] FAIL abort_done cycle %0d got %b expected 0", c, done); else passCount++;
                checkCount++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy cycle %0d got %b expected 0", c, busy); else passCount++;
                checkCount++; if (dataReady !== 1'b0) $display("[TB] FAIL abort_data_ready cycle %0d got %b expected 0", c, dataReady); else passCount++;
            end
            step();
        end
        cmdValid = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; cmdValid = 1'b0; cmd = '0;
        dataValid = 1'b0; data = '0;
        step();
        test_reset();
        test_mul();
        test_load();
        test_back_to_back();
        test_illegal();
        test_enable_freeze();
        test_reset_abort();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
